// File: rtl/uart_pixel_rx.sv
// UART receiver that turns each good byte from the Nano into a frame-buffer pixel write.
// Addresses advance sequentially, wrap every IMAGE_SIZE pixels, and reset after a long mid-frame idle.
module uart_pixel_rx #(
   parameter int CLKS_PER_BIT      = 434,
   parameter int BITS_N            = 8,
   parameter int PARITY_TYPE       = 0,
   parameter int IMAGE_SIZE        = 76800,
   parameter int IDLE_TIMEOUT_BITS = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
   output logic [BITS_N-1:0]             pixel_data,
   output logic [$clog2(IMAGE_SIZE)-1:0] pixel_addr,
   output logic                          pixel_valid,
   output logic                          frame_done,
   output logic                          frame_abort,
   output logic                          parity_error,
   output logic                          framing_error,
   output logic                          busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(BITS_N + 1);
   localparam int AW = $clog2(IMAGE_SIZE);
   localparam int TO = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW = $clog2(TO + 1);

   localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_N - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(IMAGE_SIZE - 1);
   localparam logic [TW-1:0] TO_M1     = TW'(TO - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   state_t            state, state_next;
   logic              rx_meta, rs;
   logic [CW-1:0]     cnt;
   logic [BW-1:0]     bitcnt;
   logic [BITS_N-1:0] shreg;
   logic              par_bad;
   logic [TW-1:0]     idle_cnt;
   logic              tick_half, tick_full, stop_sample, good_byte, timeout;

   // Two-flop synchroniser; the line idles high so both flops reset to 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rs      <= 1'b1;
      end else begin
         rx_meta <= rx;
         rs      <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic; every sample point is the last cycle of a bit-period count.
   always_comb begin
      state_next  = state;
      stop_sample = 1'b0;
      tick_half   = (cnt == HALF_M1);
      tick_full   = (cnt == FULL_M1);
      case (state)
         IDLE:      if (!rs) state_next = START;
         START:     if (tick_half) state_next = rs ? IDLE : DATA;
         DATA:      if (tick_full && (bitcnt == LAST_BIT))
                       state_next = (PARITY_TYPE != 0) ? PARITY : STOP;
         PARITY:    if (tick_full) state_next = STOP;
         STOP:      if (tick_full) begin
                       stop_sample = 1'b1;
                       state_next  = rs ? IDLE : WAIT_HIGH;
                    end
         WAIT_HIGH: if (rs) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   assign good_byte = stop_sample && rs && !par_bad;
   assign timeout   = (state == IDLE) && rs && (pixel_addr != '0) && (idle_cnt == TO_M1);
   assign busy      = (state != IDLE);

   // Bit timing, LSB-first shift register and parity tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         bitcnt  <= '0;
         shreg   <= '0;
         par_bad <= 1'b0;
      end else begin
         if (state == IDLE || state == WAIT_HIGH || state_next != state || tick_full)
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);
         if (state == IDLE) begin
            bitcnt  <= '0;
            par_bad <= 1'b0;
         end
         if (state == DATA && tick_full) begin
            shreg  <= BITS_N'({rs, shreg} >> 1);
            bitcnt <= bitcnt + BW'(1);
         end
         if (state == PARITY && tick_full)
            par_bad <= (PARITY_TYPE == 1) ? ~(^{shreg, rs}) : (^{shreg, rs});
      end
   end

   // Output strobes and the frame-buffer address; a timeout overrides the normal increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         pixel_data    <= '0;
         pixel_addr    <= '0;
         pixel_valid   <= 1'b0;
         frame_done    <= 1'b0;
         frame_abort   <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         pixel_valid   <= good_byte;
         frame_done    <= good_byte && (pixel_addr == LAST_ADDR);
         parity_error  <= stop_sample && rs && par_bad;
         framing_error <= stop_sample && !rs;
         frame_abort   <= timeout;
         if (good_byte) pixel_data <= shreg;
         if (timeout)
            pixel_addr <= '0;
         else if (pixel_valid)
            pixel_addr <= (pixel_addr == LAST_ADDR) ? '0 : pixel_addr + AW'(1);
      end
   end

   // Idle counter only runs between bytes of a partially received frame.
   always_ff @(posedge clk) begin
      if (rst || state != IDLE || !rs || pixel_addr == '0 || timeout)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + TW'(1);
   end

endmodule

// File: tb/tb_uart_pixel_rx.sv
// Bench for uart_pixel_rx: one no-parity and one even-parity instance, each with a scoreboard
// of expected pixel writes popped by a monitor whenever pixel_valid is seen.
module tb_uart_pixel_rx;

   localparam int CPB  = 8;
   localparam int BITS = 8;
   localparam int IMG  = 4;
   localparam int TOB  = 16;
   localparam int TO   = TOB * CPB;
   localparam int LAT0 = 3 + CPB / 2 + CPB * (BITS + 1);
   localparam int LAT2 = LAT0 + CPB;

   typedef struct {
      logic [7:0] data;
      logic [1:0] addr;
      logic       fd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx0 = 1'b1;
   logic       rx2 = 1'b1;
   logic [7:0] pd0, pd2;
   logic [1:0] pa0, pa2;
   logic       pv0, fd0, fa0, pe0, fe0, bz0;
   logic       pv2, fd2, fa2, pe2, fe2, bz2;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   pv_cyc0, pv_cyc2, abort_cyc0;
   int   perr0, ferr0, abort0, fdcnt0;
   int   perr2, ferr2, abort2;
   exp_t q0[$];
   exp_t q2[$];
   exp_t e0, e2;

   uart_pixel_rx #(.CLKS_PER_BIT(CPB), .BITS_N(BITS), .PARITY_TYPE(0),
                   .IMAGE_SIZE(IMG), .IDLE_TIMEOUT_BITS(TOB)) u_dut0 (
      .clk(clk), .rst(rst), .rx(rx0),
      .pixel_data(pd0), .pixel_addr(pa0), .pixel_valid(pv0), .frame_done(fd0),
      .frame_abort(fa0), .parity_error(pe0), .framing_error(fe0), .busy(bz0));

   uart_pixel_rx #(.CLKS_PER_BIT(CPB), .BITS_N(BITS), .PARITY_TYPE(2),
                   .IMAGE_SIZE(IMG), .IDLE_TIMEOUT_BITS(TOB)) u_dut2 (
      .clk(clk), .rst(rst), .rx(rx2),
      .pixel_data(pd2), .pixel_addr(pa2), .pixel_valid(pv2), .frame_done(fd2),
      .frame_abort(fa2), .parity_error(pe2), .framing_error(fe2), .busy(bz2));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitors: every pixel write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (pv0) begin
         n_checks++;
         if (q0.size() == 0) begin
            $display("[TB] FAIL dut0_unexpected_pixel: got data=%h addr=%0d, expected no write", pd0, pa0);
         end else begin
            e0 = q0.pop_front();
            pv_cyc0 = cyc;
            if ({pd0, pa0, fd0} !== {e0.data, e0.addr, e0.fd})
               $display("[TB] FAIL dut0_pixel: got data=%h addr=%0d done=%b, expected data=%h addr=%0d done=%b",
                        pd0, pa0, fd0, e0.data, e0.addr, e0.fd);
            else n_pass++;
         end
      end else if (fd0) begin
         n_checks++;
         $display("[TB] FAIL dut0_frame_done_alone: got frame_done=1 with pixel_valid=0, expected 0");
      end
      if (fd0) fdcnt0++;
      if (pe0) perr0++;
      if (fe0) ferr0++;
      if (fa0) begin abort0++; abort_cyc0 = cyc; end
   end

   always @(negedge clk) begin
      if (pv2) begin
         n_checks++;
         if (q2.size() == 0) begin
            $display("[TB] FAIL dut2_unexpected_pixel: got data=%h addr=%0d, expected no write", pd2, pa2);
         end else begin
            e2 = q2.pop_front();
            pv_cyc2 = cyc;
            if ({pd2, pa2, fd2} !== {e2.data, e2.addr, e2.fd})
               $display("[TB] FAIL dut2_pixel: got data=%h addr=%0d done=%b, expected data=%h addr=%0d done=%b",
                        pd2, pa2, fd2, e2.data, e2.addr, e2.fd);
            else n_pass++;
         end
      end
      if (pe2) perr2++;
      if (fe2) ferr2++;
      if (fa2) abort2++;
   end

   task automatic set_rx(input int which, input logic v);
      if (which == 0) rx0 = v;
      else            rx2 = v;
   endtask

   task automatic drive_bits(input int which, input logic v, input int n);
      set_rx(which, v);
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic send_frame(input int which, input logic [7:0] d, input bit use_par,
                             input logic par, input logic stop_v, input int stop_n);
      drive_bits(which, 1'b0, 1);
      for (int i = 0; i < BITS; i++) drive_bits(which, d[i], 1);
      if (use_par) drive_bits(which, par, 1);
      drive_bits(which, stop_v, stop_n);
      set_rx(which, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rx0 = 1'b1;
      rx2 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      perr0 = 0; ferr0 = 0; abort0 = 0; fdcnt0 = 0;
      perr2 = 0; ferr2 = 0; abort2 = 0;
   endtask

   task automatic wait_drain(input int which, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (which == 0 && q0.size() == 0) break;
         if (which == 2 && q2.size() == 0) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx0 = 1'b1;
      rx2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({pd0, pa0, pv0, fd0, fa0, pe0, fe0, bz0, pd2, pa2, pv2, fd2, fa2, pe2, fe2, bz2} !== '0)
            $display("[TB] FAIL reset_outputs: got dut0=%h/%0d/%b%b%b%b%b%b dut2=%h/%0d/%b%b%b%b%b%b, expected all 0",
                     pd0, pa0, pv0, fd0, fa0, pe0, fe0, bz0, pd2, pa2, pv2, fd2, fa2, pe2, fe2, bz2);
         else n_pass++;
      end
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n_checks++;
         if ({pv0, fd0, fa0, pe0, fe0, bz0, pa0, pv2, fd2, fa2, pe2, fe2, bz2, pa2} !== '0)
            $display("[TB] FAIL idle_quiet: got dut0=%b%b%b%b%b%b addr=%0d dut2=%b%b%b%b%b%b addr=%0d, expected all 0",
                     pv0, fd0, fa0, pe0, fe0, bz0, pa0, pv2, fd2, fa2, pe2, fe2, bz2, pa2);
         else n_pass++;
      end
   endtask

   task automatic test_single_byte();
      int t0;
      do_reset();
      q0.push_back('{data: 8'hA5, addr: 2'd0, fd: 1'b0});
      t0 = cyc;
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1);
      wait_drain(0, 200);
      n_checks++;
      if (q0.size() !== 0) $display("[TB] FAIL single_written: got %0d pending, expected 0", q0.size());
      else n_pass++;
      n_checks++;
      if (pv_cyc0 - t0 !== LAT0) $display("[TB] FAIL single_latency: got %0d, expected %0d", pv_cyc0 - t0, LAT0);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (pa0 !== 2'd1) $display("[TB] FAIL single_addr_after: got %0d, expected 1", pa0);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [1:0] addrs [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      for (int i = 0; i < 5; i++)
         q0.push_back('{data: 8'(i + 1), addr: addrs[i], fd: (i == 3)});
      for (int i = 0; i < 5; i++)
         send_frame(0, 8'(i + 1), 1'b0, 1'b0, 1'b1, 1);
      wait_drain(0, 200);
      @(negedge clk);
      n_checks++;
      if (q0.size() !== 0) $display("[TB] FAIL wrap_written: got %0d pending, expected 0", q0.size());
      else n_pass++;
      n_checks++;
      if (fdcnt0 !== 1) $display("[TB] FAIL wrap_frame_done_count: got %0d, expected 1", fdcnt0);
      else n_pass++;
      n_checks++;
      if (pa0 !== 2'd1) $display("[TB] FAIL wrap_addr_after: got %0d, expected 1", pa0);
      else n_pass++;
   endtask

   task automatic test_parity();
      int t0;
      do_reset();
      send_frame(2, 8'h03, 1'b1, 1'b1, 1'b1, 1);
      repeat (5) @(negedge clk);
      n_checks++;
      if (perr2 !== 1) $display("[TB] FAIL parity_bad_pulse: got %0d pulses, expected 1", perr2);
      else n_pass++;
      n_checks++;
      if (pa2 !== 2'd0) $display("[TB] FAIL parity_bad_addr: got %0d, expected 0", pa2);
      else n_pass++;
      q2.push_back('{data: 8'h03, addr: 2'd0, fd: 1'b0});
      t0 = cyc;
      send_frame(2, 8'h03, 1'b1, 1'b0, 1'b1, 1);
      wait_drain(2, 200);
      n_checks++;
      if (q2.size() !== 0) $display("[TB] FAIL parity_good_written: got %0d pending, expected 0", q2.size());
      else n_pass++;
      n_checks++;
      if (pv_cyc2 - t0 !== LAT2) $display("[TB] FAIL parity_latency: got %0d, expected %0d", pv_cyc2 - t0, LAT2);
      else n_pass++;
      n_checks++;
      if (perr2 !== 1) $display("[TB] FAIL parity_good_no_error: got %0d pulses, expected 1", perr2);
      else n_pass++;
   endtask

   task automatic test_framing();
      do_reset();
      drive_bits(0, 1'b0, 1);
      for (int i = 0; i < BITS; i++) drive_bits(0, 1'(8'h5A >> i), 1);
      drive_bits(0, 1'b0, 10);
      n_checks++;
      if (bz0 !== 1'b1) $display("[TB] FAIL break_busy_mid: got %b, expected 1", bz0);
      else n_pass++;
      drive_bits(0, 1'b0, 10);
      n_checks++;
      if (bz0 !== 1'b1) $display("[TB] FAIL break_busy_end: got %b, expected 1", bz0);
      else n_pass++;
      rx0 = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if (bz0 !== 1'b0) $display("[TB] FAIL break_busy_release: got %b, expected 0", bz0);
      else n_pass++;
      n_checks++;
      if ({ferr0, perr0} !== {32'd1, 32'd0})
         $display("[TB] FAIL break_errors: got framing=%0d parity=%0d, expected framing=1 parity=0", ferr0, perr0);
      else n_pass++;
      send_frame(2, 8'h03, 1'b1, 1'b1, 1'b0, 1);
      repeat (5) @(negedge clk);
      n_checks++;
      if ({ferr2, perr2} !== {32'd1, 32'd0})
         $display("[TB] FAIL framing_precedence: got framing=%0d parity=%0d, expected framing=1 parity=0", ferr2, perr2);
      else n_pass++;
      rx0 = 1'b0;
      repeat (2) @(negedge clk);
      rx0 = 1'b1;
      repeat (4 * CPB) @(negedge clk);
      n_checks++;
      if ({ferr0, perr0, abort0, bz0, pa0} !== {32'd1, 32'd0, 32'd0, 1'b0, 2'd0})
         $display("[TB] FAIL glitch_quiet: got framing=%0d parity=%0d abort=%0d busy=%b addr=%0d, expected 1 0 0 0 0",
                  ferr0, perr0, abort0, bz0, pa0);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int pv_last;
      do_reset();
      q0.push_back('{data: 8'h11, addr: 2'd0, fd: 1'b0});
      q0.push_back('{data: 8'h22, addr: 2'd1, fd: 1'b0});
      send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1);
      send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1, 1);
      wait_drain(0, 200);
      @(negedge clk);
      pv_last = pv_cyc0;
      n_checks++;
      if (pa0 !== 2'd2) $display("[TB] FAIL timeout_addr_before: got %0d, expected 2", pa0);
      else n_pass++;
      repeat (TO - 2 * CPB) @(negedge clk);
      n_checks++;
      if (abort0 !== 0) $display("[TB] FAIL timeout_early: got %0d aborts, expected 0", abort0);
      else n_pass++;
      for (int k = 0; k < 4 * CPB && abort0 == 0; k++) @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (abort0 !== 1 || pa0 !== 2'd0)
         $display("[TB] FAIL timeout_abort: got aborts=%0d addr=%0d, expected aborts=1 addr=0", abort0, pa0);
      else n_pass++;
      n_checks++;
      if (abort_cyc0 - pv_last < TO - 2 || abort_cyc0 - pv_last > TO + 2)
         $display("[TB] FAIL timeout_delay: got %0d cycles, expected %0d +/-2", abort_cyc0 - pv_last, TO);
      else n_pass++;
      repeat (2 * TO) @(negedge clk);
      n_checks++;
      if (abort0 !== 1) $display("[TB] FAIL timeout_once: got %0d aborts, expected 1", abort0);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      q0.push_back('{data: 8'h3C, addr: 2'd0, fd: 1'b0});
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1);
      wait_drain(0, 200);
      drive_bits(0, 1'b0, 1);
      for (int i = 0; i < 3; i++) drive_bits(0, 1'(8'hF0 >> i), 1);
      n_checks++;
      if ({bz0, pa0} !== {1'b1, 2'd1}) $display("[TB] FAIL midframe_pre: got busy=%b addr=%0d, expected busy=1 addr=1", bz0, pa0);
      else n_pass++;
      rst = 1'b1;
      rx0 = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({pd0, pa0, pv0, fd0, fa0, pe0, fe0, bz0} !== '0)
         $display("[TB] FAIL midframe_reset: got data=%h addr=%0d flags=%b%b%b%b%b busy=%b, expected all 0",
                  pd0, pa0, pv0, fd0, fa0, pe0, fe0, bz0);
      else n_pass++;
      rst = 1'b0;
      repeat (12 * CPB) @(negedge clk);
      n_checks++;
      if ({ferr0, perr0, bz0, pa0} !== {32'd0, 32'd0, 1'b0, 2'd0})
         $display("[TB] FAIL midframe_after: got framing=%0d parity=%0d busy=%b addr=%0d, expected 0 0 0 0",
                  ferr0, perr0, bz0, pa0);
      else n_pass++;
   endtask

   initial begin
      $display("[TB] uart_pixel_rx bench starting");
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_parity();
      test_framing();
      test_timeout();
      test_reset_mid_frame();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_pixel_rx.md
Name: uart_pixel_rx

Overview:
- Receive-side counterpart of the FPGA-to-Nano pixel sender: deserialises UART frames arriving from the Nano on a GPIO pin.
- Checks optional parity and the stop bit.
- Emits each good byte as a pixel write with a sequential frame-buffer address, wrapping every IMAGE_SIZE pixels.
- Sits between the GPIO RX pin and the image RAM write port.

Parameters:
- CLKS_PER_BIT, 434 (50000000/115200), clock cycles per UART bit; must be >= 4.
- BITS_N, 8, data bits per UART frame (1..9).
- PARITY_TYPE, 0, 0 = none, 1 = odd, 2 = even.
- IMAGE_SIZE, 76800, pixels per frame.
- IDLE_TIMEOUT_BITS, 16, line-idle bit periods mid-frame before the frame is aborted.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous UART serial line; idles high.
- pixel_data  output  BITS_N  received byte.
- pixel_addr  output  $clog2(IMAGE_SIZE)  frame-buffer write address for pixel_data.
- pixel_valid  output  1  one-cycle write strobe.
- frame_done  output  1  one-cycle pulse, coincident with the pixel_valid of address IMAGE_SIZE-1.
- frame_abort  output  1  one-cycle pulse on idle timeout mid-frame.
- parity_error  output  1  one-cycle pulse; byte discarded.
- framing_error  output  1  one-cycle pulse on bad stop bit; byte discarded.
- busy  output  1  high while not in IDLE.

Behaviour:
- Reset:
  - Synchronous, evaluated on the clk edge, wins over all other activity including mid-frame.
  - All outputs 0; pixel_addr = 0; FSM = IDLE; both rx sync flops = 1.
- Input synchronisation:
  - rx passes through a 2-flop synchroniser; all logic uses the synchronised value rs.
  - Adds 2 cycles of latency.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on rs = 0, go to START and clear the bit counter.
  - START: after CLKS_PER_BIT/2 cycles, resample rs. If 0, go to DATA; if 1 (glitch), return to IDLE with no error pulse.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), LSB first, into a shift register. After BITS_N samples, go to PARITY if PARITY_TYPE != 0, else STOP.
  - PARITY: sample one bit. For odd parity, XOR of data and parity bit must be 1; for even, it must be 0. Record a mismatch, then go to STOP.
  - STOP: sample one bit at mid-bit.
    - rs = 1 and no parity mismatch: pixel_data and pixel_valid are registered on the next clk edge (pixel_valid one cycle after the stop sample); go to IDLE.
    - rs = 1 with parity mismatch: parity_error pulses, no pixel_valid; go to IDLE.
    - rs = 0: framing_error pulses (takes precedence over parity_error; only one error pulse per byte); go to WAIT_HIGH.
  - WAIT_HIGH: stay until rs = 1, then go to IDLE. This prevents a break condition from being read as a start bit.
- Address:
  - pixel_addr holds the address of the current pixel_valid.
  - It increments on the cycle after each pixel_valid.
  - At IMAGE_SIZE-1, frame_done pulses with pixel_valid and the address wraps to 0.
  - Discarded bytes do not advance the address.
- Idle timeout:
  - An idle counter runs only while FSM = IDLE and pixel_addr != 0, and clears on any start bit.
  - On reaching IDLE_TIMEOUT_BITS*CLKS_PER_BIT cycles, frame_abort pulses and pixel_addr resets to 0 on the same edge.
  - No timeout counting occurs when pixel_addr = 0.
- Width rule: counters are sized with $clog2 so that CLKS_PER_BIT, BITS_N, IMAGE_SIZE and the timeout count fit; there is no silent truncation.
- busy = (FSM != IDLE).

Test Plan:
- Reset and idle: CLKS_PER_BIT=8, IMAGE_SIZE=4; hold rst for 3 cycles with rx=1. All outputs remain 0 and pixel_addr = 0; after release, 100 idle cycles produce no pulse.
- Single byte, no parity: send 0xA5 LSB-first with a valid stop bit. Exactly one pixel_valid with pixel_data = 0xA5 and pixel_addr = 0, asserted one cycle after the stop mid-sample; pixel_addr then reads 1.
- Full frame and wrap: send 0x01..0x05 back-to-back with IMAGE_SIZE=4. Addresses are 0,1,2,3,0; frame_done pulses only with 0x04 at address 3.
- Parity:
  - PARITY_TYPE=2, send 0x03 with parity bit 1: parity_error pulses, no pixel_valid, pixel_addr unchanged.
  - Then send 0x03 with parity bit 0: pixel_valid with 0x03.
- Framing and glitch:
  - A stop bit held low for 20 bit periods gives one framing_error, busy stays high until rx returns high, and no pixel is written.
  - A 2-cycle low glitch on rx gives no pulse at all.
- Timeout and reset mid-frame:
  - After 2 bytes, idle for IDLE_TIMEOUT_BITS*CLKS_PER_BIT cycles: frame_abort pulses once and pixel_addr = 0.
  - Asserting rst during DATA: the next cycle shows the IDLE state with all outputs 0, and the partial byte is never written.
